// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the multi-cycle divider: state encoding, widths,
// the divide-by-zero quotient and the {rem, quot} result packing.
package div_ctrl_pkg;

    localparam int unsigned DIV_WIDTH     = 32;
    localparam int unsigned DIV_RES_WIDTH = 2 * DIV_WIDTH;

    typedef enum logic [1:0] {
        DIV_IDLE    = 2'd0,
        DIV_DIVZERO = 2'd1,
        DIV_BUSY    = 2'd2,
        DIV_DONE    = 2'd3
    } div_state_e;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

    // Remainder in the upper half, quotient in the lower half (EX double-reg layout)
    typedef struct packed {
        logic [DIV_WIDTH-1:0] rem;
        logic [DIV_WIDTH-1:0] quot;
    } div_result_t;

endpackage

// File: rtl/div_ctrl_step.sv
// One radix-2 restoring step: shift {rem, quot} left, subtract the divisor
// when it fits, and shift the resulting quotient bit in.
module div_step
    import div_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quot,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quot
);

    logic [WIDTH:0]   w_rem_sh;
    logic             w_fits;
    logic [WIDTH-1:0] w_diff;

    // The partial remainder stays below the divisor, so the difference fits in WIDTH bits
    assign w_rem_sh = {i_rem, i_quot[WIDTH-1]};
    assign w_fits   = w_rem_sh >= {1'b0, i_divisor};
    assign w_diff   = w_rem_sh[WIDTH-1:0] - i_divisor;
    assign o_rem    = w_fits ? w_diff : w_rem_sh[WIDTH-1:0];
    assign o_quot   = {i_quot[WIDTH-2:0], w_fits};

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle integer divide controller for the EX stage: sign handling,
// divide-by-zero, abort, and a one-cycle done pulse with {rem, quot}.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               div_start_i,
    input  logic               div_signed_i,
    input  logic [WIDTH-1:0]   div_data1_i,
    input  logic [WIDTH-1:0]   div_data2_i,
    output logic [2*WIDTH-1:0] div_result_o,
    output logic               div_done_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    div_state_e         r_state;
    div_state_e         w_state_nxt;
    logic               r_signed;
    logic               r_qsign;
    logic               r_rsign;
    logic [WIDTH-1:0]   r_dividend;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quot;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_result;
    logic               r_done;

    logic               w_accept;
    logic               w_abort;
    logic               w_last;
    logic [WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]   w_dvs_mag;
    logic [WIDTH-1:0]   w_rem_step;
    logic [WIDTH-1:0]   w_quot_step;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    div_result_t        w_capture;

    assign w_accept  = div_start_i & ~flush_i;
    assign w_abort   = flush_i | ~div_start_i;
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_dvd_mag = (div_signed_i && div_data1_i[WIDTH-1]) ? -div_data1_i : div_data1_i;
    assign w_dvs_mag = (div_signed_i && div_data2_i[WIDTH-1]) ? -div_data2_i : div_data2_i;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_quot    (r_quot),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_step),
        .o_quot    (w_quot_step)
    );

    assign w_quot_fix = (r_signed && r_qsign) ? -w_quot_step : w_quot_step;
    assign w_rem_fix  = (r_signed && r_rsign) ? -w_rem_step  : w_rem_step;

    // Result presented on entry to DONE; divide-by-zero returns the raw dividend
    always_comb begin
        w_capture.rem  = w_rem_fix;
        w_capture.quot = w_quot_fix;
        if (r_state == DIV_DIVZERO) begin
            w_capture.rem  = r_dividend;
            w_capture.quot = DIV_ZERO_QUOT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DIV_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (div_data2_i == '0) ? DIV_DIVZERO : DIV_BUSY;
                end
            end
            DIV_DIVZERO: w_state_nxt = w_abort ? DIV_IDLE : DIV_DONE;
            DIV_BUSY: begin
                if (w_abort) begin
                    w_state_nxt = DIV_IDLE;
                end else if (w_last) begin
                    w_state_nxt = DIV_DONE;
                end
            end
            DIV_DONE: w_state_nxt = DIV_IDLE;
            default:  w_state_nxt = DIV_IDLE;
        endcase
    end

    // Operand latch, iteration datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_signed   <= 1'b0;
            r_qsign    <= 1'b0;
            r_rsign    <= 1'b0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (w_state_nxt == DIV_DONE);
            if (r_state == DIV_IDLE && w_accept) begin
                r_signed   <= div_signed_i;
                r_qsign    <= div_data1_i[WIDTH-1] ^ div_data2_i[WIDTH-1];
                r_rsign    <= div_data1_i[WIDTH-1];
                r_dividend <= div_data1_i;
                r_divisor  <= w_dvs_mag;
                r_rem      <= '0;
                r_quot     <= w_dvd_mag;
                r_cnt      <= '0;
            end else if (r_state == DIV_BUSY) begin
                r_rem  <= w_rem_step;
                r_quot <= w_quot_step;
                r_cnt  <= CNT_W'(r_cnt + 1'b1);
            end
            if (w_state_nxt == DIV_DONE) begin
                r_result <= w_capture;
            end
        end
    end

    assign div_result_o = r_result;
    assign div_done_o   = r_done;

endmodule
